hw_ctrl_seq: RTL and testbench
==============================

# hw_ctrl_seq

Parametrised hardwired controller with an internal beat sequencer for the teaching CPU. It replaces externally supplied W1–W3 beats with an on-chip beat counter and generalises register-console access to NREG registers through an index counter. It adds a single-instruction step mode and a synchronised QD start handshake. It sits between the console switches/IR and the datapath control lines.

## Interface
- NREG, 4, number of datapath registers; power of two, ≥2; RW = log2(NREG)
- SYNC, 2, synchroniser stages on qd
- clk  in  1  beat clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-low
- qd  in  1  asynchronous start push-button
- swcba  in  3  console mode {SWC,SWB,SWA}
- ir_op  in  4  IR[7:4] opcode
- c, z  in  1 each  ALU carry/zero flags
- w  out  3  one-hot beat {W3,W2,W1}; 0 when not running
- running  out  1  sequencer active
- st0  out  1  mode phase flag
- reg_idx  out  RW  console register index
- sel_ctl, abus, m, drw, sbus, lir, mbus, memw, lar, arinc, lpc, pcinc, pcadd, cin, ldc, ldz  out  1 each  datapath controls
- s  out  4  ALU function
- sel_a, sel_b  out  RW each  register selects, valid when sel_ctl=1

## Operation
- Reset values: running=0, beat=W1, w=0, st0=0, reg_idx=0, every control output 0, s=0.
- All control outputs are combinational from (swcba, st0, reg_idx, ir_op, c, z, w). They are forced to 0 while running=0.
- Beat sequencer: W1→W2→W3→W1. Sequence length per beat:
  - SHORT ends the sequence after W1.
  - LONG extends the sequence to W3.
  - Otherwise the sequence ends after W2.
- stop_req, when asserted in a beat, clears running at that beat's closing edge. The beat resets to W1.
- Mode 000, run:
  - st0=0: W1 sbus, lpc, short; st0←1; stop_req. This loads the PC from the switches.
  - st0=1, W1: lir, pcinc.
  - W2/W3 by opcode:
    - 0001 ADD: abus, drw, ldc, ldz, cin; s=1001.
    - 0010 SUB: abus, drw, ldc, ldz; s=0110.
    - 0011 AND: m, abus, drw, ldz; s=1011.
    - 0100 INC: abus, drw, ldc, ldz; s=0000.
    - 0101 LD: W2 m, abus, lar, long, s=1010; W3 mbus, drw.
    - 0110 ST: W2 m, abus, lar, long, s=1111; W3 m, abus, s=1010, memw.
    - 0111 JC: W2 pcadd=c.
    - 1000 JZ: W2 pcadd=z.
    - 1001 JMP: m, abus, lpc; s=1111.
    - 1010 OUT: m, abus; s=1010.
    - 1011 OR: m, abus, drw, ldz; s=1110.
    - 1100 XAND: m, abus, drw, ldz; s=0100.
    - 1101 LSHIFT: cin, abus, drw, ldc, ldz; s=1100.
    - 1110 STP: W2 stop_req.
    - 0000 and 1111 are NOP, 2 beats.
- Mode 101, step: identical to 000, but stop_req is asserted on the last beat of every instruction.
- Mode 001, write memory: W1 only. sbus, short, sel_ctl, stop_req. st0=0: lar, st0←1. st0=1: memw, arinc.
- Mode 010, read memory: W1 only. short, sel_ctl, stop_req. st0=0: sbus, lar, st0←1. st0=1: mbus, arinc.
- Mode 011, read registers: W1 only. sel_ctl, short, stop_req. sel_a=reg_idx, sel_b=reg_idx+1 mod NREG. reg_idx←reg_idx+2 mod NREG at end of beat.
- Mode 100, write registers: W1 only. sel_ctl, sbus, drw, short, stop_req. sel_a=reg_idx. reg_idx←reg_idx+1 mod NREG.
- Modes 110 and 111: no controls. Sequencer runs idle single W1 beats with stop_req.
- Mode change: when swcba differs from its value registered at the previous edge, st0←0 and reg_idx←0 at the next edge. While running, the beat also returns to W1 and running←0.

## Timing
- qd passes through SYNC flops, then a rising-edge detector, then running←1.
- With SYNC=2, the first W1 appears 3 edges after qd rises. A held qd does not retrigger.
- A qd edge that occurs while running=1 is ignored.
- Latency per instruction: 2 clks by default, 3 clks for LD/ST. Console operations take 1 clk.
- stop_req in beat k: w=0 from the cycle after beat k.
- st0 and reg_idx update on the closing edge of the beat that requests them.
- clr low: immediate return to reset values, even mid-instruction. Release is synchronous-safe; no beat is issued until the next qd edge.

## Test plan
- Reset then start: clr pulse, mode 000, qd rise → 3 edges later, W1 with sbus=lpc=short=1. st0=1 after that beat, then running=0.
- Run ADD/LD/JC: ir_op=0001 → 2 beats, W2 s=1001, drw=ldc=ldz=1. ir_op=0101 → 3 beats, W3 mbus=drw=1. ir_op=0111 with c=0 → pcadd=0; with c=1 → pcadd=1.
- STP and step: run mode with ir_op=1110 → running drops after W2. Mode 101 with ADD → exactly one 2-beat instruction per qd edge.
- Register console, NREG=8: mode 100, 9 qd pulses → sel_a sequence 0..7, then 0. Mode 011 → sel_a/sel_b pairs (0,1), (2,3), (4,5), (6,7), (0,1).
- Memory console: mode 001, 3 qd pulses → first lar, then memw+arinc twice. Switch to 010 → st0 returns to 0, and the first beat asserts lar.
- Mid-op abort: clr low during W2 of ST → all outputs 0 immediately, st0=0. A mode change during W2 → running=0 at the next edge.

Source files
------------

// File: rtl/hw_ctrl_seq.sv
// hw_ctrl_seq: hardwired controller for the teaching CPU with an on-chip beat sequencer.
// A synchronised rising edge on qd starts the sequencer. Beats run W1 -> W2 -> W3 until the
// active operation requests a stop. Console modes read and write memory or registers one beat
// per qd edge. Register access walks an index counter through NREG registers.
//
// Ports:
//   clk, clr             beat clock; asynchronous active-low reset
//   qd                   asynchronous start push-button
//   swcba                console mode {SWC,SWB,SWA}
//   ir_op, c, z          IR opcode and ALU flags
//   w                    one-hot beat {W3,W2,W1}; zero while idle
//   running, st0         sequencer active; mode phase flag
//   reg_idx              console register index
//   sel_ctl .. ldz, s    datapath controls, all zero while idle
//   sel_a, sel_b         register selects, meaningful when sel_ctl=1
module hw_ctrl_seq #(
  parameter int unsigned NREG = 4,
  parameter int unsigned SYNC = 2,
  localparam int unsigned RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          qd,
  input  logic [2:0]    swcba,
  input  logic [3:0]    ir_op,
  input  logic          c,
  input  logic          z,
  output logic [2:0]    w,
  output logic          running,
  output logic          st0,
  output logic [RW-1:0] reg_idx,
  output logic          sel_ctl,
  output logic          abus,
  output logic          m,
  output logic          drw,
  output logic          sbus,
  output logic          lir,
  output logic          mbus,
  output logic          memw,
  output logic          lar,
  output logic          arinc,
  output logic          lpc,
  output logic          pcinc,
  output logic          pcadd,
  output logic          cin,
  output logic          ldc,
  output logic          ldz,
  output logic [3:0]    s,
  output logic [RW-1:0] sel_a,
  output logic [RW-1:0] sel_b
);

  typedef enum logic [1:0] {BeatW1, BeatW2, BeatW3} beat_e;

  logic          running_q, running_d;
  beat_e         beat_q, beat_d;
  logic          st0_q, st0_d;
  logic [RW-1:0] idx_q, idx_d, idx_add;
  logic [2:0]    sw_q;
  logic [SYNC-1:0] sync_q;
  logic          qd_prev_q;

  logic qd_rise, mode_chg;
  logic short_seq, long_seq, stop_req, st0_set, seq_end;

  assign qd_rise  = sync_q[SYNC-1] & ~qd_prev_q;
  assign mode_chg = (swcba != sw_q);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      running_q <= 1'b0;
      beat_q    <= BeatW1;
      st0_q     <= 1'b0;
      idx_q     <= '0;
      sw_q      <= 3'b000;
      sync_q    <= '0;
      qd_prev_q <= 1'b0;
    end else begin
      running_q <= running_d;
      beat_q    <= beat_d;
      st0_q     <= st0_d;
      idx_q     <= idx_d;
      sw_q      <= swcba;
      sync_q[0] <= qd;
      for (int i = 1; i < int'(SYNC); i++) sync_q[i] <= sync_q[i-1];
      qd_prev_q <= sync_q[SYNC-1];
    end
  end

  always_comb begin
    sel_ctl = 1'b0; abus = 1'b0; m = 1'b0; drw = 1'b0; sbus = 1'b0; lir = 1'b0;
    mbus = 1'b0; memw = 1'b0; lar = 1'b0; arinc = 1'b0; lpc = 1'b0; pcinc = 1'b0;
    pcadd = 1'b0; cin = 1'b0; ldc = 1'b0; ldz = 1'b0;
    s = 4'b0000; sel_a = '0; sel_b = '0;
    short_seq = 1'b0; long_seq = 1'b0; stop_req = 1'b0; st0_set = 1'b0; idx_add = '0;

    if (running_q) begin
      unique case (swcba)
        3'b000, 3'b101: begin
          if (!st0_q) begin
            // First beat after entering run/step loads the PC from the switches.
            sbus = 1'b1; lpc = 1'b1; short_seq = 1'b1; st0_set = 1'b1; stop_req = 1'b1;
          end else begin
            unique case (beat_q)
              BeatW1: begin lir = 1'b1; pcinc = 1'b1; end
              BeatW2: begin
                unique case (ir_op)
                  4'b0001: begin abus = 1'b1; drw = 1'b1; ldc = 1'b1; ldz = 1'b1; cin = 1'b1;
                                 s = 4'b1001; end
                  4'b0010: begin abus = 1'b1; drw = 1'b1; ldc = 1'b1; ldz = 1'b1; s = 4'b0110; end
                  4'b0011: begin m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; s = 4'b1011; end
                  4'b0100: begin abus = 1'b1; drw = 1'b1; ldc = 1'b1; ldz = 1'b1; s = 4'b0000; end
                  4'b0101: begin m = 1'b1; abus = 1'b1; lar = 1'b1; long_seq = 1'b1;
                                 s = 4'b1010; end
                  4'b0110: begin m = 1'b1; abus = 1'b1; lar = 1'b1; long_seq = 1'b1;
                                 s = 4'b1111; end
                  4'b0111: pcadd = c;
                  4'b1000: pcadd = z;
                  4'b1001: begin m = 1'b1; abus = 1'b1; lpc = 1'b1; s = 4'b1111; end
                  4'b1010: begin m = 1'b1; abus = 1'b1; s = 4'b1010; end
                  4'b1011: begin m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; s = 4'b1110; end
                  4'b1100: begin m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; s = 4'b0100; end
                  4'b1101: begin cin = 1'b1; abus = 1'b1; drw = 1'b1; ldc = 1'b1; ldz = 1'b1;
                                 s = 4'b1100; end
                  4'b1110: stop_req = 1'b1;
                  default: ;  // NOP
                endcase
              end
              BeatW3: begin
                if (ir_op == 4'b0101) begin
                  mbus = 1'b1; drw = 1'b1;
                end else if (ir_op == 4'b0110) begin
                  m = 1'b1; abus = 1'b1; memw = 1'b1; s = 4'b1010;
                end
              end
              default: ;
            endcase
          end
        end
        3'b001: begin
          sbus = 1'b1; short_seq = 1'b1; sel_ctl = 1'b1; stop_req = 1'b1;
          if (!st0_q) begin lar = 1'b1; st0_set = 1'b1; end
          else begin memw = 1'b1; arinc = 1'b1; end
        end
        3'b010: begin
          short_seq = 1'b1; sel_ctl = 1'b1; stop_req = 1'b1;
          if (!st0_q) begin sbus = 1'b1; lar = 1'b1; st0_set = 1'b1; end
          else begin mbus = 1'b1; arinc = 1'b1; end
        end
        3'b011: begin
          sel_ctl = 1'b1; short_seq = 1'b1; stop_req = 1'b1;
          sel_a = idx_q; sel_b = idx_q + RW'(1); idx_add = RW'(2);
        end
        3'b100: begin
          sel_ctl = 1'b1; sbus = 1'b1; drw = 1'b1; short_seq = 1'b1; stop_req = 1'b1;
          sel_a = idx_q; idx_add = RW'(1);
        end
        default: begin short_seq = 1'b1; stop_req = 1'b1; end
      endcase
    end

    seq_end = (beat_q == BeatW1 && short_seq) || (beat_q == BeatW2 && !long_seq) ||
              (beat_q == BeatW3);
    // Step mode halts at the last beat of every instruction.
    if (running_q && swcba == 3'b101 && seq_end) stop_req = 1'b1;

    unique case (beat_q)
      BeatW1:  w = running_q ? 3'b001 : 3'b000;
      BeatW2:  w = running_q ? 3'b010 : 3'b000;
      BeatW3:  w = running_q ? 3'b100 : 3'b000;
      default: w = 3'b000;
    endcase
    running = running_q;
    st0     = st0_q;
    reg_idx = idx_q;

    running_d = running_q;
    beat_d    = beat_q;
    st0_d     = st0_q;
    idx_d     = idx_q + idx_add;
    if (running_q) begin
      if (stop_req || seq_end) beat_d = BeatW1;
      else if (beat_q == BeatW1) beat_d = BeatW2;
      else beat_d = BeatW3;
      if (stop_req) running_d = 1'b0;
    end else if (qd_rise) begin
      running_d = 1'b1;
      beat_d    = BeatW1;
    end
    if (st0_set) st0_d = 1'b1;
    // A console mode change restarts the mode phase and cancels any beat in flight.
    if (mode_chg) begin
      st0_d = 1'b0;
      idx_d = '0;
      if (running_q) begin
        running_d = 1'b0;
        beat_d    = BeatW1;
      end
    end
  end

endmodule

// File: tb/tb_hw_ctrl_seq.sv
// Bench for hw_ctrl_seq (NREG=8): directed scenarios plus randomized runs, every cycle compared
// against a beat-level reference model built from the instruction table.
module tb_hw_ctrl_seq;
  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = 3;

  localparam logic [15:0] M_SEL = 16'h8000, M_ABUS = 16'h4000, M_M = 16'h2000;
  localparam logic [15:0] M_DRW = 16'h1000, M_SBUS = 16'h0800, M_LIR = 16'h0400;
  localparam logic [15:0] M_MBUS = 16'h0200, M_MEMW = 16'h0100, M_LAR = 16'h0080;
  localparam logic [15:0] M_ARINC = 16'h0040, M_LPC = 16'h0020, M_PCINC = 16'h0010;
  localparam logic [15:0] M_PCADD = 16'h0008, M_CIN = 16'h0004, M_LDC = 16'h0002;
  localparam logic [15:0] M_LDZ = 16'h0001;

  logic clk = 1'b0;
  logic clr, qd, c, z;
  logic [2:0] swcba;
  logic [3:0] ir_op;
  logic [2:0] w;
  logic running, st0;
  logic [RW-1:0] reg_idx, sel_a, sel_b;
  logic sel_ctl, abus, m, drw, sbus, lir, mbus, memw, lar, arinc, lpc, pcinc, pcadd, cin;
  logic ldc, ldz;
  logic [3:0] s;
  logic [15:0] ctl;

  assign ctl = {sel_ctl, abus, m, drw, sbus, lir, mbus, memw, lar, arinc, lpc, pcinc, pcadd,
                cin, ldc, ldz};

  hw_ctrl_seq #(.NREG(NREG), .SYNC(2)) dut (
    .clk(clk), .clr(clr), .qd(qd), .swcba(swcba), .ir_op(ir_op), .c(c), .z(z),
    .w(w), .running(running), .st0(st0), .reg_idx(reg_idx),
    .sel_ctl(sel_ctl), .abus(abus), .m(m), .drw(drw), .sbus(sbus), .lir(lir), .mbus(mbus),
    .memw(memw), .lar(lar), .arinc(arinc), .lpc(lpc), .pcinc(pcinc), .pcadd(pcadd),
    .cin(cin), .ldc(ldc), .ldz(ldz), .s(s), .sel_a(sel_a), .sel_b(sel_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit       m_run;
  int       m_beat;   // 1..3
  bit       m_st0;
  int       m_idx;
  logic [2:0] m_last_sw;
  int       m_pend[$]; // edges remaining until a qd rise reaches the start logic

  // Per-run observations
  int act_beats, first_i;
  logic [15:0] cap_ctl [3];
  logic [3:0]  cap_s [3];
  int last_sa, last_sb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int instr_len(input logic [2:0] md, input bit st, input logic [3:0] op);
    if ((md == 3'd0 || md == 3'd5) && st) return (op == 4'd5 || op == 4'd6) ? 3 : 2;
    return 1;
  endfunction

  function automatic bit stops_at(input logic [2:0] md, input bit st, input logic [3:0] op,
                                  input int beat);
    int len = instr_len(md, st, op);
    if (len == 1) return 1'b1;
    if (op == 4'd14 && beat == 2) return 1'b1;
    if (md == 3'd5 && beat == len) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void exp_out(input logic [2:0] md, input bit st, input int idx,
                                  input logic [3:0] op, input bit cc, input bit zz,
                                  input int beat, input bit run, output logic [15:0] ec,
                                  output logic [3:0] es, output int sa, output int sb);
    ec = '0; es = '0; sa = 0; sb = 0;
    if (!run) return;
    case (md)
      3'd0, 3'd5: begin
        if (!st) ec = M_SBUS | M_LPC;
        else if (beat == 1) ec = M_LIR | M_PCINC;
        else if (beat == 2) begin
          case (op)
            4'd1:  begin ec = M_ABUS | M_DRW | M_LDC | M_LDZ | M_CIN; es = 4'd9; end
            4'd2:  begin ec = M_ABUS | M_DRW | M_LDC | M_LDZ; es = 4'd6; end
            4'd3:  begin ec = M_M | M_ABUS | M_DRW | M_LDZ; es = 4'd11; end
            4'd4:  begin ec = M_ABUS | M_DRW | M_LDC | M_LDZ; es = 4'd0; end
            4'd5:  begin ec = M_M | M_ABUS | M_LAR; es = 4'd10; end
            4'd6:  begin ec = M_M | M_ABUS | M_LAR; es = 4'd15; end
            4'd7:  ec = cc ? M_PCADD : 16'h0;
            4'd8:  ec = zz ? M_PCADD : 16'h0;
            4'd9:  begin ec = M_M | M_ABUS | M_LPC; es = 4'd15; end
            4'd10: begin ec = M_M | M_ABUS; es = 4'd10; end
            4'd11: begin ec = M_M | M_ABUS | M_DRW | M_LDZ; es = 4'd14; end
            4'd12: begin ec = M_M | M_ABUS | M_DRW | M_LDZ; es = 4'd4; end
            4'd13: begin ec = M_CIN | M_ABUS | M_DRW | M_LDC | M_LDZ; es = 4'd12; end
            default: ;
          endcase
        end else begin
          if (op == 4'd5) ec = M_MBUS | M_DRW;
          if (op == 4'd6) begin ec = M_M | M_ABUS | M_MEMW; es = 4'd10; end
        end
      end
      3'd1: ec = M_SEL | M_SBUS | (st ? (M_MEMW | M_ARINC) : M_LAR);
      3'd2: ec = M_SEL | (st ? (M_MBUS | M_ARINC) : (M_SBUS | M_LAR));
      3'd3: begin ec = M_SEL; sa = idx; sb = (idx + 1) % NREG; end
      3'd4: begin ec = M_SEL | M_SBUS | M_DRW; sa = idx; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_beat = 1; m_st0 = 1'b0; m_idx = 0; m_last_sw = 3'd0;
    m_pend.delete();
  endtask

  task automatic model_edge();
    bit pre_run = m_run;
    bit fire = 1'b0;
    for (int i = 0; i < m_pend.size(); i++) m_pend[i] = m_pend[i] - 1;
    if (m_pend.size() != 0 && m_pend[0] == 0) begin
      fire = 1'b1;
      void'(m_pend.pop_front());
    end
    if (m_run) begin
      int  len  = instr_len(swcba, m_st0, ir_op);
      bit  stop = stops_at(swcba, m_st0, ir_op, m_beat);
      if ((swcba == 3'd0 || swcba == 3'd5 || swcba == 3'd1 || swcba == 3'd2) && !m_st0)
        m_st0 = 1'b1;
      if (swcba == 3'd3) m_idx = (m_idx + 2) % NREG;
      if (swcba == 3'd4) m_idx = (m_idx + 1) % NREG;
      if (stop) begin m_run = 1'b0; m_beat = 1; end
      else if (m_beat == len) m_beat = 1;
      else m_beat = m_beat + 1;
    end else if (fire) begin
      m_run = 1'b1; m_beat = 1;
    end
    if (swcba != m_last_sw) begin
      m_st0 = 1'b0; m_idx = 0;
      if (pre_run) begin m_run = 1'b0; m_beat = 1; end
    end
    m_last_sw = swcba;
  endtask

  task automatic check_all();
    logic [15:0] ec;
    logic [3:0]  es;
    int sa, sb;
    logic [2:0] ew;
    exp_out(swcba, m_st0, m_idx, ir_op, c, z, m_beat, m_run, ec, es, sa, sb);
    ew = m_run ? 3'(1 << (m_beat - 1)) : 3'd0;
    check_eq("w", w, ew);
    check_eq("running", running, m_run);
    check_eq("st0", st0, m_st0);
    check_eq("reg_idx", reg_idx, m_idx);
    check_eq("ctl", ctl, ec);
    check_eq("s", s, es);
    check_eq("sel_a", sel_a, sa);
    check_eq("sel_b", sel_b, sb);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_reset();
    #2 clr = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic set_mode(input logic [2:0] md);
    swcba = md;
    cycle();
  endtask

  task automatic pulse_qd();
    qd = 1'b1;
    m_pend.push_back(3);
    cycle();
    qd = 1'b0;
    cycle();
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    act_beats = 0; first_i = -1;
    for (int i = 0; i < budget; i++) begin
      if (!m_run && m_pend.size() == 0 && qd == 1'b0) break;
      if (rnd) begin
        ir_op = 4'($urandom); c = 1'($urandom); z = 1'($urandom);
        if (qd) qd = 1'b0;
        else if ($urandom_range(0, 9) == 0) begin qd = 1'b1; m_pend.push_back(3); end
      end
      cycle();
      if (w != 3'd0) begin
        if (first_i < 0) first_i = i;
        if (act_beats < 3) begin cap_ctl[act_beats] = ctl; cap_s[act_beats] = s; end
        act_beats++;
        last_sa = int'(sel_a); last_sb = int'(sel_b);
      end
    end
    if (m_run || m_pend.size() != 0 || qd) begin
      // Long run-mode program: stop it with a mode change and drain pending starts.
      qd = 1'b0;
      swcba = (swcba == 3'd6) ? 3'd7 : 3'd6;
      for (int j = 0; j < 6; j++) cycle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; qd = 1'b0; swcba = 3'd0; ir_op = 4'd0; c = 1'b0; z = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();
    check_eq("rst_w", w, 0);
    check_eq("rst_ctl", ctl, 0);

    // Start in run mode: PC load beat three edges after qd rises.
    set_mode(3'd0);
    pulse_qd();
    wait_idle(10, 1'b0);
    check_eq("qd_latency", 2 + first_i + 1, 3);
    check_eq("start_beats", act_beats, 1);
    check_eq("start_ctl", cap_ctl[0], M_SBUS | M_LPC);
    check_eq("start_st0", st0, 1);

    // Step mode instructions.
    set_mode(3'd5);
    pulse_qd(); wait_idle(10, 1'b0);
    ir_op = 4'd1; pulse_qd(); wait_idle(10, 1'b0);
    check_eq("add_beats", act_beats, 2);
    check_eq("add_w2", cap_ctl[1], M_ABUS | M_DRW | M_LDC | M_LDZ | M_CIN);
    check_eq("add_s", cap_s[1], 4'b1001);
    ir_op = 4'd5; pulse_qd(); wait_idle(10, 1'b0);
    check_eq("ld_beats", act_beats, 3);
    check_eq("ld_w3", cap_ctl[2], M_MBUS | M_DRW);
    ir_op = 4'd7; c = 1'b0; pulse_qd(); wait_idle(10, 1'b0);
    check_eq("jc0_w2", cap_ctl[1], 0);
    c = 1'b1; pulse_qd(); wait_idle(10, 1'b0);
    check_eq("jc1_w2", cap_ctl[1], M_PCADD);

    // STP in run mode.
    set_mode(3'd0);
    pulse_qd(); wait_idle(10, 1'b0);
    ir_op = 4'd14; pulse_qd(); wait_idle(10, 1'b0);
    check_eq("stp_beats", act_beats, 2);

    // Register write console walks 0..7 then wraps.
    set_mode(3'd4);
    for (int i = 0; i < 9; i++) begin
      pulse_qd(); wait_idle(10, 1'b0);
      check_eq("wreg_sel_a", last_sa, i % 8);
    end
    set_mode(3'd3);
    for (int i = 0; i < 5; i++) begin
      pulse_qd(); wait_idle(10, 1'b0);
      check_eq("rreg_sel_a", last_sa, (2 * i) % 8);
      check_eq("rreg_sel_b", last_sb, (2 * i + 1) % 8);
    end

    // Memory consoles.
    set_mode(3'd1);
    pulse_qd(); wait_idle(10, 1'b0);
    check_eq("wmem_first", cap_ctl[0], M_SEL | M_SBUS | M_LAR);
    for (int i = 0; i < 2; i++) begin
      pulse_qd(); wait_idle(10, 1'b0);
      check_eq("wmem_next", cap_ctl[0], M_SEL | M_SBUS | M_MEMW | M_ARINC);
    end
    set_mode(3'd2);
    check_eq("rmem_st0", st0, 0);
    pulse_qd(); wait_idle(10, 1'b0);
    check_eq("rmem_first", cap_ctl[0], M_SEL | M_SBUS | M_LAR);

    // Mode change during W2 of ADD.
    set_mode(3'd0);
    pulse_qd(); wait_idle(10, 1'b0);
    ir_op = 4'd1; pulse_qd();
    for (int i = 0; i < 6; i++) begin
      if (m_run && m_beat == 2) break;
      cycle();
    end
    swcba = 3'd3;
    cycle();
    check_eq("modechg_running", running, 0);
    check_eq("modechg_w", w, 0);

    // clr during W2 of ST.
    set_mode(3'd0);
    pulse_qd(); wait_idle(10, 1'b0);
    ir_op = 4'd6; pulse_qd();
    for (int i = 0; i < 6; i++) begin
      if (m_run && m_beat == 2) break;
      cycle();
    end
    apply_reset();
    check_eq("abort_st0", st0, 0);
    check_eq("abort_ctl", ctl, 0);

    // Randomized sessions.
    for (int it = 0; it < 60; it++) begin
      logic [2:0] md;
      md = 3'($urandom_range(0, 7));
      if (md != swcba) set_mode(md);
      ir_op = 4'($urandom); c = 1'($urandom); z = 1'($urandom);
      pulse_qd();
      wait_idle(40, 1'b1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
